channel_fifo_rr_mux: RTL and testbench

- Parametrised successor to the fixed three-stream channel FIFO service.
- Buffers NUM_CH independent packet streams (sop/eop/empty framing) in per-channel FIFOs and merges them onto one output stream using packet-atomic round-robin arbitration.
- Tags every output flit with its source channel and exports per-channel fill levels and packet statistics.
- Sits between the packet ingress shims and the single-stream downstream pipeline in one clock domain.

---
 rtl/chfifo_pkg.sv | 10 +
 rtl/chfifo_ch_buf.sv | 59 +++++
 rtl/channel_fifo_rr_mux.sv | 111 +++++++++++
 tb/tb_channel_fifo_rr_mux.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/chfifo_pkg.sv
// chfifo_pkg: shared arbiter state type and flit width helper for the channel FIFO mux
package chfifo_pkg;

   typedef enum logic {IDLE, LOCKED} arb_state_t;

   function automatic int flit_w(int data_w, int empty_w);
      return data_w + empty_w + 2;
   endfunction

endpackage

// File: rtl/chfifo_ch_buf.sv
// chfifo_ch_buf: single-channel show-ahead FIFO with fill count, almost-full and eop counter
module chfifo_ch_buf
   import chfifo_pkg::*;
#(
   parameter int DATA_W    = 512,
   parameter int EMPTY_W   = 6,
   parameter int DEPTH     = 64,
   parameter int AF_MARGIN = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sop,
   input  logic                     in_eop,
   input  logic [EMPTY_W-1:0]       in_empty,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     pop,
   output logic                     head_sop,
   output logic                     head_eop,
   output logic [EMPTY_W-1:0]       head_empty,
   output logic [DATA_W-1:0]        head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full,
   output logic [31:0]              pkt_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = flit_w(DATA_W, EMPTY_W);

   logic [FW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push;

   assign in_ready    = count != (AW+1)'(DEPTH);
   assign almost_full = count >= (AW+1)'(DEPTH - AF_MARGIN);
   assign push        = in_valid & in_ready;
   assign {head_sop, head_eop, head_empty, head_data} = mem[rd_ptr];

   // flit storage, written unmodified on accept
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {in_sop, in_eop, in_empty, in_data};

   // pointers, occupancy and accepted-packet counter
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         pkt_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (push && in_eop) pkt_cnt <= pkt_cnt + 1'b1;
      end

endmodule

// File: rtl/channel_fifo_rr_mux.sv
// channel_fifo_rr_mux: per-channel FIFOs merged by packet-atomic round-robin onto one tagged stream
module channel_fifo_rr_mux
   import chfifo_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = 512,
   parameter int EMPTY_W   = 6,
   parameter int DEPTH     = 64,
   parameter int AF_MARGIN = 8,
   parameter int CH_W      = $clog2(NUM_CH)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_CH-1:0]                   in_valid,
   output logic [NUM_CH-1:0]                   in_ready,
   input  logic [NUM_CH-1:0]                   in_sop,
   input  logic [NUM_CH-1:0]                   in_eop,
   input  logic [NUM_CH*DATA_W-1:0]            in_data,
   input  logic [NUM_CH*EMPTY_W-1:0]           in_empty,
   output logic [NUM_CH-1:0]                   in_almost_full,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                out_sop,
   output logic                                out_eop,
   output logic [DATA_W-1:0]                   out_data,
   output logic [EMPTY_W-1:0]                  out_empty,
   output logic [CH_W-1:0]                     out_channel,
   output logic [NUM_CH*($clog2(DEPTH)+1)-1:0] fill_level,
   output logic [NUM_CH*32-1:0]                stats_in_pkt,
   output logic [31:0]                         stats_out_pkt
);

   localparam int LW = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0]  head_data  [NUM_CH];
   logic [EMPTY_W-1:0] head_empty [NUM_CH];
   logic [LW-1:0]      cnt        [NUM_CH];
   logic [NUM_CH-1:0]  head_sop, head_eop, pop, nonempty;
   arb_state_t         state, nxt_state;
   logic [CH_W-1:0]    grant, nxt_grant, last_grant, nxt_last, idx;
   logic               out_fire;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      chfifo_ch_buf #(
         .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)
      ) u_buf (
         .clk(clk),
         .rst_n(rst_n),
         .in_valid(in_valid[i]),
         .in_ready(in_ready[i]),
         .in_sop(in_sop[i]),
         .in_eop(in_eop[i]),
         .in_empty(in_empty[i*EMPTY_W +: EMPTY_W]),
         .in_data(in_data[i*DATA_W +: DATA_W]),
         .pop(pop[i]),
         .head_sop(head_sop[i]),
         .head_eop(head_eop[i]),
         .head_empty(head_empty[i]),
         .head_data(head_data[i]),
         .count(cnt[i]),
         .almost_full(in_almost_full[i]),
         .pkt_cnt(stats_in_pkt[i*32 +: 32])
      );
      assign fill_level[i*LW +: LW] = cnt[i];
      assign nonempty[i]            = cnt[i] != '0;
      assign pop[i]                 = out_fire && grant == CH_W'(i);
   end

   assign out_valid   = state == LOCKED && nonempty[grant];
   assign out_fire    = out_valid & out_ready;
   assign out_sop     = head_sop[grant];
   assign out_eop     = head_eop[grant];
   assign out_data    = head_data[grant];
   assign out_empty   = head_empty[grant];
   assign out_channel = grant;

   // next grant: nearest non-empty channel after last_grant; release only on accepted eop
   always_comb begin
      nxt_state = state;
      nxt_grant = grant;
      nxt_last  = last_grant;
      idx       = '0;
      if (state == IDLE) begin
         for (int k = NUM_CH; k >= 1; k--) begin
            idx = CH_W'((int'(last_grant) + k) % NUM_CH);
            if (nonempty[idx]) begin
               nxt_grant = idx;
               nxt_state = LOCKED;
            end
         end
      end else if (out_fire && out_eop) begin
         nxt_state = IDLE;
         nxt_last  = grant;
      end
   end

   // arbiter registers and output packet counter
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= IDLE;
         grant         <= '0;
         last_grant    <= CH_W'(NUM_CH - 1);
         stats_out_pkt <= '0;
      end else begin
         state      <= nxt_state;
         grant      <= nxt_grant;
         last_grant <= nxt_last;
         if (out_fire && out_eop) stats_out_pkt <= stats_out_pkt + 1'b1;
      end

endmodule

// File: tb/tb_channel_fifo_rr_mux.sv
// tb_channel_fifo_rr_mux: scoreboard bench for the round-robin channel FIFO mux
module tb_channel_fifo_rr_mux;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 32;
   localparam int EMPTY_W = 2;
   localparam int DEPTH = 16;
   localparam int AF_MARGIN = 4;
   localparam int CH_W = 2;
   localparam int LW = 5;

   logic                      clk = 0;
   logic                      rst_n = 0;
   logic [NUM_CH-1:0]         in_valid = '0, in_sop = '0, in_eop = '0;
   logic [NUM_CH-1:0]         in_ready, in_almost_full;
   logic [NUM_CH*DATA_W-1:0]  in_data = '0;
   logic [NUM_CH*EMPTY_W-1:0] in_empty = '0;
   logic                      out_valid, out_sop, out_eop;
   logic                      out_ready = 0;
   logic [DATA_W-1:0]         out_data;
   logic [EMPTY_W-1:0]        out_empty;
   logic [CH_W-1:0]           out_channel;
   logic [NUM_CH*LW-1:0]      fill_level;
   logic [NUM_CH*32-1:0]      stats_in_pkt;
   logic [31:0]               stats_out_pkt;

   channel_fifo_rr_mux #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W),
      .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .CH_W(CH_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
      .in_data(in_data), .in_empty(in_empty), .in_almost_full(in_almost_full),
      .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
      .out_data(out_data), .out_empty(out_empty), .out_channel(out_channel),
      .fill_level(fill_level), .stats_in_pkt(stats_in_pkt), .stats_out_pkt(stats_out_pkt)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] exp_q [$];
   bit          last_eop_hs = 0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pack(int ch, bit sop, bit eop, logic [1:0] emp, logic [31:0] dat);
      return {26'b0, 2'(ch), sop, eop, emp, dat};
   endfunction

   function automatic logic [31:0] dval(int t, int ch, int idx);
      return 32'(t) << 24 | 32'(ch) << 16 | 32'(idx);
   endfunction

   // output scoreboard and inter-packet bubble check
   always @(negedge clk) begin
      if (last_eop_hs) chk("bubble", 64'(out_valid), 64'd0);
      last_eop_hs = out_valid && out_ready && out_eop;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("extra_flit", 64'(out_valid), 64'd0);
         else chk("flit", pack(out_channel, out_sop, out_eop, out_empty, out_data), exp_q.pop_front());
      end
   end

   task automatic set_lane(int ch, bit sop, bit eop, logic [1:0] emp, logic [31:0] dat);
      in_valid[ch] = 1;
      in_sop[ch] = sop;
      in_eop[ch] = eop;
      in_empty[ch*EMPTY_W +: EMPTY_W] = emp;
      in_data[ch*DATA_W +: DATA_W] = dat;
   endtask

   task automatic expect_flit(int ch, bit sop, bit eop, logic [1:0] emp, logic [31:0] dat);
      exp_q.push_back(pack(ch, sop, eop, emp, dat));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      in_valid = '0;
   endtask

   task automatic do_reset();
      #1;
      rst_n = 0;
      in_valid = '0;
      out_ready = 0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic wait_drain(string tag);
      for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
      repeat (6) @(posedge clk);
      #1;
      chk(tag, 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [LW-1:0] fl(int ch);
      return fill_level[ch*LW +: LW];
   endfunction

   initial begin
      // reset state
      #1;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_channel", 64'(out_channel), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'hF);
      chk("rst_almost_full", 64'(in_almost_full), 64'd0);
      chk("rst_fill_level", 64'(fill_level), 64'd0);
      chk("rst_stats_in", 64'(stats_in_pkt[63:0]) | 64'(stats_in_pkt[127:64]), 64'd0);
      chk("rst_stats_out", 64'(stats_out_pkt), 64'd0);
      rst_n = 1;
      repeat (3) step();
      chk("idle_out_valid", 64'(out_valid), 64'd0);

      // single 3-flit packet on channel 2
      out_ready = 1;
      set_lane(2, 1, 0, 2'd0, dval(2, 2, 0));
      expect_flit(2, 1, 0, 2'd0, dval(2, 2, 0));
      step();
      chk("lat_edge0", 64'(out_valid), 64'd0);
      set_lane(2, 0, 0, 2'd0, dval(2, 2, 1));
      expect_flit(2, 0, 0, 2'd0, dval(2, 2, 1));
      step();
      chk("lat_edge1", 64'(out_valid), 64'd1);
      chk("lat_channel", 64'(out_channel), 64'd2);
      set_lane(2, 0, 1, 2'd3, dval(2, 2, 2));
      expect_flit(2, 0, 1, 2'd3, dval(2, 2, 2));
      step();
      wait_drain("t2_drain");
      chk("t2_stats_in2", 64'(stats_in_pkt[2*32 +: 32]), 64'd1);
      chk("t2_stats_out", 64'(stats_out_pkt), 64'd1);

      // all four channels pending from reset: order 0,1,2,3
      do_reset();
      for (int c = 0; c < NUM_CH; c++) set_lane(c, 1, 0, 2'd0, dval(3, c, 0));
      step();
      for (int c = 0; c < NUM_CH; c++) set_lane(c, 0, 1, 2'(c), dval(3, c, 1));
      step();
      for (int c = 0; c < NUM_CH; c++) begin
         expect_flit(c, 1, 0, 2'd0, dval(3, c, 0));
         expect_flit(c, 0, 1, 2'(c), dval(3, c, 1));
      end
      out_ready = 1;
      wait_drain("t3_drain");
      chk("t3_stats_out", 64'(stats_out_pkt), 64'd4);

      // fill channel 1 to capacity with the output stalled
      do_reset();
      for (int f = 0; f < DEPTH; f++) begin
         set_lane(1, f == 0, f == DEPTH - 1, 2'd1, dval(4, 1, f));
         expect_flit(1, f == 0, f == DEPTH - 1, 2'd1, dval(4, 1, f));
         step();
         if (f == 10) chk("af_at_11", 64'(in_almost_full[1]), 64'd0);
         if (f == 11) chk("af_at_12", 64'(in_almost_full[1]), 64'd1);
         if (f == 14) chk("ready_at_15", 64'(in_ready[1]), 64'd1);
      end
      chk("full_ready", 64'(in_ready[1]), 64'd0);
      chk("full_level", 64'(fl(1)), 64'd16);
      set_lane(1, 1, 1, 2'd2, dval(4, 1, 99));
      step();
      chk("overflow_level", 64'(fl(1)), 64'd16);
      chk("overflow_stats", 64'(stats_in_pkt[1*32 +: 32]), 64'd1);
      out_ready = 1;
      wait_drain("t4_drain");
      chk("t4_level_after", 64'(fl(1)), 64'd0);

      // channel 0 starves mid-packet while channel 3 waits
      do_reset();
      out_ready = 1;
      set_lane(0, 1, 0, 2'd0, dval(5, 0, 0));
      expect_flit(0, 1, 0, 2'd0, dval(5, 0, 0));
      step();
      set_lane(3, 1, 0, 2'd0, dval(5, 3, 0));
      step();
      set_lane(3, 0, 1, 2'd2, dval(5, 3, 1));
      step();
      repeat (4) step();
      chk("starve_valid", 64'(out_valid), 64'd0);
      chk("starve_channel", 64'(out_channel), 64'd0);
      chk("starve_level3", 64'(fl(3)), 64'd2);
      set_lane(0, 0, 1, 2'd1, dval(5, 0, 1));
      expect_flit(0, 0, 1, 2'd1, dval(5, 0, 1));
      expect_flit(3, 1, 0, 2'd0, dval(5, 3, 0));
      expect_flit(3, 0, 1, 2'd2, dval(5, 3, 1));
      step();
      wait_drain("t5_drain");

      // asynchronous reset mid-packet discards buffered flits
      do_reset();
      for (int f = 0; f < 5; f++) begin
         set_lane(2, f == 0, 0, 2'd0, dval(6, 2, f));
         step();
      end
      chk("t6_level2", 64'(fl(2)), 64'd5);
      chk("t6_valid_pre", 64'(out_valid), 64'd1);
      rst_n = 0;
      #2;
      chk("t6_async_valid", 64'(out_valid), 64'd0);
      chk("t6_async_level", 64'(fl(2)), 64'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1;
      out_ready = 1;
      repeat (20) step();
      chk("t6_no_residual", 64'(out_valid), 64'd0);
      chk("t6_stats_out", 64'(stats_out_pkt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
